// File: rtl/boruss_mem_arbiter.sv
// rtl/boruss_mem_arbiter.sv - two-port arbiter sequencing single accesses onto the memory controller data port
module boruss_mem_arbiter #(
  parameter int READ_LATENCY  = 1,
  parameter int PRIORITY_MODE = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic       sel0,
  input  logic       sel1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data_in,
  output logic       mem_write_enable,
  output logic       mem_read_enable,
  output logic       mem_map_select,
  input  logic [7:0] mem_data_out,
  output logic       busy,
  output logic       grant_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_t     state;
  logic [2:0] wait_cnt;
  logic       last_grant;
  logic       lat_we;
  logic       winner;

  // Round-robin only matters on a tie; a sole requester always wins.
  always_comb begin
    winner = 1'b0;
    if (PRIORITY_MODE == 1) begin
      winner = ~req0;
    end else if (req0 && req1) begin
      winner = ~last_grant;
    end else begin
      winner = ~req0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      wait_cnt         <= 3'd0;
      last_grant       <= 1'b1;
      lat_we           <= 1'b0;
      ack0             <= 1'b0;
      ack1             <= 1'b0;
      rdata0           <= 8'd0;
      rdata1           <= 8'd0;
      mem_addr         <= 8'd0;
      mem_data_in      <= 8'd0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_map_select   <= 1'b0;
      busy             <= 1'b0;
      grant_id         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant_id         <= winner;
            last_grant       <= winner;
            lat_we           <= winner ? we1 : we0;
            mem_addr         <= winner ? addr1 : addr0;
            mem_data_in      <= winner ? wdata1 : wdata0;
            mem_map_select   <= winner ? sel1 : sel0;
            mem_write_enable <= winner ? we1 : we0;
            mem_read_enable  <= winner ? ~we1 : ~we0;
            busy             <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          // The enable pulse lives for exactly this one cycle.
          mem_addr         <= 8'd0;
          mem_data_in      <= 8'd0;
          mem_map_select   <= 1'b0;
          mem_write_enable <= 1'b0;
          mem_read_enable  <= 1'b0;
          if (lat_we) begin
            ack0  <= ~grant_id;
            ack1  <= grant_id;
            state <= ACK;
          end else begin
            wait_cnt <= LAT;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt <= 3'd1) begin
            wait_cnt <= 3'd0;
            if (grant_id) begin
              rdata1 <= mem_data_out;
              ack1   <= 1'b1;
            end else begin
              rdata0 <= mem_data_out;
              ack0   <= 1'b1;
            end
            state <= ACK;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ACK: begin
          ack0   <= 1'b0;
          ack1   <= 1'b0;
          rdata0 <= 8'd0;
          rdata1 <= 8'd0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
